clk_switch_ctrl: RTL and testbench
==================================

Name: clk_switch_ctrl

Overview:
- Sequencer for the 4:1 PLL clock mux and its output clock gate.
- Accepts clock-source change requests via a valid/ready handshake and drives the mux select and gate enable in a safe order: gate off, wait, switch, settle, gate on.
- Runs on an always-on reference clock. Its outputs feed the mux select and gate enable of the clock output stage.

Parameters:
- RESET_SEL, 2'd0, mux select driven during and after reset.
- GATE_OFF_CYCLES, 4, cycles held in GATE_OFF with en_o low before the select changes (≥1).
- MUX_SETTLE_CYCLES, 4, cycles held in SWITCH after the select changes, gate still off (≥1).
- GATE_ON_CYCLES, 2, cycles held in GATE_ON before completion is reported (≥1).

Ports:
- clk_i  input  1  always-on reference clock
- rst_i  input  1  synchronous active-high reset
- req_valid_i  input  1  switch request valid
- req_sel_i  input  2  requested PLL index
- req_ready_o  output  1  request accepted when valid & ready
- run_en_i  input  1  software gate enable while not switching
- sel_o  output  2  mux select
- en_o  output  1  clock gate enable
- busy_o  output  1  switch sequence in progress
- done_o  output  1  one-cycle pulse when a request completes

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values (rst_i sampled high):
  - state = IDLE, sel_o = RESET_SEL, en_o = 0, busy_o = 0, done_o = 0.
  - req_ready_o = 0 while rst_i is high.
- States: IDLE, GATE_OFF, SWITCH, GATE_ON.
  - One shared down-counter, width $clog2 of the largest delay parameter plus 1.
  - The counter loads on each state entry.
- IDLE:
  - req_ready_o = 1 (combinational, = state==IDLE & !rst_i).
  - en_o is register-updated from run_en_i each cycle (1-cycle latency).
- Accept at edge E0 with req_sel_i ≠ sel_o:
  - Request is latched. State goes to GATE_OFF; en_o = 0 and busy_o = 1 after E0.
- GATE_OFF → SWITCH after GATE_OFF_CYCLES cycles. sel_o takes the latched value on SWITCH entry (E4 with defaults).
- SWITCH → GATE_ON after MUX_SETTLE_CYCLES cycles. On GATE_ON entry, en_o = run_en_i; it keeps tracking run_en_i during GATE_ON.
- GATE_ON → IDLE after GATE_ON_CYCLES cycles. done_o = 1 for exactly the first IDLE cycle; busy_o = 0.
- Latency: done_o is high GATE_OFF_CYCLES + MUX_SETTLE_CYCLES + GATE_ON_CYCLES cycles after E0 (10 with defaults).
- Accept with req_sel_i == sel_o: no gate activity. done_o = 1 the next cycle; state stays IDLE; en_o keeps following run_en_i.
- req_ready_o = 0 in GATE_OFF, SWITCH and GATE_ON. A requester must hold req_valid_i stable until accepted.
- run_en_i changes during GATE_OFF/SWITCH: ignored; en_o stays 0. The value is honoured from GATE_ON entry onward.
- Reset mid-sequence: abort to IDLE at the next edge with sel_o = RESET_SEL, en_o = 0, and no done_o pulse.
- sel_o never changes while en_o is 1 (safety invariant).
- en_o is never 1 in GATE_OFF or SWITCH (safety invariant).

Optional Feature:
- Macro CLK_SWITCH_CTRL_QUEUE_EN.
- Defined:
  - A one-deep pending request register is added. req_ready_o = pending slot empty, in any state.
  - A request accepted while busy is stored.
  - On GATE_ON completion, done_o pulses and, if pending is valid, the state goes directly to GATE_OFF the same cycle. en_o stays 0; pending is cleared.
  - A pending sel equal to current sel_o yields done_o on the following cycle only.
  - Reset clears pending.
- Undefined: the register does not exist, and req_ready_o is high only in IDLE as above.

Decomposition:
- Package clk_switch_pkg holds:
  - NUM_PLL = 4 and the sel_t typedef (logic [1:0]).
  - The state_e enum (IDLE, GATE_OFF, SWITCH, GATE_ON).
  - Default delay constants.
- Sub-module clk_switch_dly_cnt:
  - Loadable down-counter with load_i, load_val_i and expired_o.
  - Instanced once, reused per state.

Test Plan:
- Reset with RESET_SEL=2 → sel_o=2, en_o=0, req_ready_o=0 during reset; after rst_i falls with run_en_i=1, en_o=1 one cycle later.
- Request sel 2→1 at E0 with run_en_i=1:
  - en_o=0 after E0, sel_o=1 after E4, en_o=1 after E8, done_o pulse after E10.
  - sel_o never changes while en_o=1.
- Request sel equal to current (1→1) → done_o pulse the cycle after accept; en_o and sel_o unchanged; busy_o stays 0.
- Drop run_en_i to 0 during SWITCH, request 0→3 → en_o stays 0 through GATE_ON; done_o still at +10; en_o remains 0 in IDLE.
- Assert rst_i during SWITCH (sel_o already new) → next cycle sel_o=RESET_SEL, en_o=0, state IDLE, no done_o.
- With CLK_SWITCH_CTRL_QUEUE_EN, request 0→1 then 1→2 while busy:
  - Second request accepted (req_ready_o=1); done_o for the first at +10.
  - GATE_OFF re-entered immediately with en_o kept 0; sel_o=2 four cycles later; second done_o 10 cycles after the first.

Source files
------------

// File: rtl/clk_switch_pkg.sv
// rtl/clk_switch_pkg.sv - shared types and default delays for the PLL clock switch sequencer
package clk_switch_pkg;

    localparam int NUM_PLL = 4;

    typedef logic [$clog2(NUM_PLL)-1:0] sel_t;

    typedef enum logic [1:0] {
        IDLE,
        GATE_OFF,
        SWITCH,
        GATE_ON
    } state_e;

    localparam int DEF_GATE_OFF_CYCLES   = 4;
    localparam int DEF_MUX_SETTLE_CYCLES = 4;
    localparam int DEF_GATE_ON_CYCLES    = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clk_switch_dly_cnt.sv
// rtl/clk_switch_dly_cnt.sv - loadable down-counter shared by all sequencer delay states
module clk_switch_dly_cnt #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt;

    // Holds at zero once expired so an idle counter reads as expired.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired_o = (cnt == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - gate-off / switch / settle / gate-on sequencer for the 4:1 PLL clock mux
// Optional one-deep request queue: CLK_SWITCH_CTRL_QUEUE_EN
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter sel_t RESET_SEL         = 2'd0,
    parameter int   GATE_OFF_CYCLES   = DEF_GATE_OFF_CYCLES,
    parameter int   MUX_SETTLE_CYCLES = DEF_MUX_SETTLE_CYCLES,
    parameter int   GATE_ON_CYCLES    = DEF_GATE_ON_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_sel_i,
    output logic       req_ready_o,
    input  logic       run_en_i,
    output logic [1:0] sel_o,
    output logic       en_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CW = $clog2(max3(GATE_OFF_CYCLES, MUX_SETTLE_CYCLES, GATE_ON_CYCLES)) + 1;

    state_e       state;
    sel_t         tgt_sel;
    logic         req_fire;
    logic         cand_valid;
    sel_t         cand_sel;
    logic         go_gate_off, go_switch, go_gate_on;
    logic         cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic         cnt_expired;

`ifdef CLK_SWITCH_CTRL_QUEUE_EN
    logic pend_valid;
    sel_t pend_sel;

    assign req_ready_o = !pend_valid && !rst_i;
    assign req_fire    = req_valid_i && req_ready_o;
    // A held request takes priority; in IDLE a fresh request bypasses the slot.
    assign cand_valid  = (state == IDLE) ? (pend_valid || req_fire) : pend_valid;
    assign cand_sel    = pend_valid ? pend_sel : req_sel_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_valid <= 1'b0;
            pend_sel   <= RESET_SEL;
        end else if (req_fire && state != IDLE) begin
            pend_valid <= 1'b1;
            pend_sel   <= req_sel_i;
        end else if (pend_valid && (state == IDLE || go_gate_off)) begin
            pend_valid <= 1'b0;
        end
    end
`else
    assign req_ready_o = (state == IDLE) && !rst_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign cand_valid  = req_fire;
    assign cand_sel    = req_sel_i;
`endif

    always_comb begin
        go_gate_off = 1'b0;
        go_switch   = 1'b0;
        go_gate_on  = 1'b0;
        case (state)
            IDLE:     go_gate_off = cand_valid && (cand_sel != sel_o);
            GATE_OFF: go_switch   = cnt_expired;
            SWITCH:   go_gate_on  = cnt_expired;
            GATE_ON:  go_gate_off = cnt_expired && cand_valid && (cand_sel != sel_o);
            default:  ;
        endcase
    end

    assign cnt_load     = go_gate_off || go_switch || go_gate_on;
    assign cnt_load_val = go_switch  ? CW'(MUX_SETTLE_CYCLES - 1) :
                          go_gate_on ? CW'(GATE_ON_CYCLES - 1)    :
                                       CW'(GATE_OFF_CYCLES - 1);

    clk_switch_dly_cnt #(
        .W (CW)
    ) u_dly_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .expired_o  (cnt_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            tgt_sel <= RESET_SEL;
            sel_o   <= RESET_SEL;
            en_o    <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    en_o <= run_en_i;
                    if (go_gate_off) begin
                        state   <= GATE_OFF;
                        tgt_sel <= cand_sel;
                        en_o    <= 1'b0;
                        busy_o  <= 1'b1;
                    end else if (cand_valid) begin
                        done_o <= 1'b1;
                    end
                end
                GATE_OFF: begin
                    if (go_switch) begin
                        state <= SWITCH;
                        sel_o <= tgt_sel;
                    end
                end
                SWITCH: begin
                    if (go_gate_on) begin
                        state <= GATE_ON;
                        en_o  <= run_en_i;
                    end
                end
                GATE_ON: begin
                    en_o <= run_en_i;
                    if (cnt_expired) begin
                        done_o <= 1'b1;
                        // Chained request: gate stays closed straight into the next sequence.
                        if (go_gate_off) begin
                            state   <= GATE_OFF;
                            tgt_sel <= cand_sel;
                            en_o    <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb/tb_clk_switch_ctrl.sv - self-checking bench for clk_switch_ctrl
module tb_clk_switch_ctrl;

`ifdef CLK_SWITCH_CTRL_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [1:0] sel;
        logic       run;
        exp_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic       run_en = 1'b1;
    logic       req_ready_o;
    logic [1:0] sel_o;
    logic       en_o, busy_o, done_o;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [1:0] prev_sel;
    logic       prev_en;

    always #5 clk = ~clk;

    clk_switch_ctrl #(
        .RESET_SEL (2'd2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_sel_i   (req_sel),
        .req_ready_o (req_ready_o),
        .run_en_i    (run_en),
        .sel_o       (sel_o),
        .en_o        (en_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    function automatic exp_t mke(input logic [1:0] s, input logic e, input logic b,
                                 input logic d, input logic r);
        exp_t x;
        x.sel = s; x.en = e; x.busy = b; x.done = d; x.ready = r;
        return x;
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s, input logic run,
                                input logic [1:0] es, input logic ee, input logic eb,
                                input logic ed, input logic er);
        vec_t x;
        x.rst = r; x.valid = v; x.sel = s; x.run = run;
        x.exp = mke(es, ee, eb, ed, er);
        return x;
    endfunction

    task automatic step(input logic r, input logic v, input logic [1:0] s, input logic run,
                        input exp_t e, input string tag, input int idx);
        exp_t want, got;
        rst = r; req_valid = v; req_sel = s; run_en = run;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = mke(sel_o, en_o, busy_o, done_o, req_ready_o);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s[%0d] got sel=%0d en=%b busy=%b done=%b ready=%b, want sel=%0d en=%b busy=%b done=%b ready=%b",
                     tag, idx, got.sel, got.en, got.busy, got.done, got.ready,
                     want.sel, want.en, want.busy, want.done, want.ready);
        end
        if (!r && sel_o !== prev_sel) begin
            n_tests++;
            if (prev_en || en_o) begin
                n_fail++;
                $display("FAIL safety[%s/%0d] sel changed %0d->%0d with en prev=%b now=%b",
                         tag, idx, prev_sel, sel_o, prev_en, en_o);
            end
        end
        prev_sel = sel_o;
        prev_en  = en_o;
    endtask

    // Reference timeline of one full switch starting at an accept edge (k = 0).
    task automatic do_switch(input logic [1:0] from_sel, input logic [1:0] to_sel,
                             input int drop_k, input int nsteps, input string tag);
        logic run;
        exp_t e;
        for (int k = 0; k < nsteps; k++) begin
            run    = (k >= drop_k) ? 1'b0 : 1'b1;
            e.sel  = (k >= 4) ? to_sel : from_sel;
            e.en   = (k >= 8) ? run : 1'b0;
            e.busy = (k < 10);
            e.done = (k == 10);
            e.ready = (k >= 10) || QUEUE;
            step(1'b0, k == 0, to_sel, run, e, tag, k);
        end
    endtask

    vec_t vecs[15];
    exp_t e;

    initial begin
        vecs[0]  = mk(1, 0, 0, 1, 2, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 1, 2, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 2, 1, 0, 0, 1);
        vecs[3]  = mk(0, 1, 1, 1, 2, 0, 1, 0, QUEUE);
        vecs[4]  = mk(0, 0, 0, 1, 2, 0, 1, 0, QUEUE);
        vecs[5]  = mk(0, 0, 0, 1, 2, 0, 1, 0, QUEUE);
        vecs[6]  = mk(0, 0, 0, 1, 2, 0, 1, 0, QUEUE);
        vecs[7]  = mk(0, 0, 0, 1, 1, 0, 1, 0, QUEUE);
        vecs[8]  = mk(0, 0, 0, 1, 1, 0, 1, 0, QUEUE);
        vecs[9]  = mk(0, 0, 0, 1, 1, 0, 1, 0, QUEUE);
        vecs[10] = mk(0, 0, 0, 1, 1, 0, 1, 0, QUEUE);
        vecs[11] = mk(0, 0, 0, 1, 1, 1, 1, 0, QUEUE);
        vecs[12] = mk(0, 0, 0, 1, 1, 1, 1, 0, QUEUE);
        vecs[13] = mk(0, 0, 0, 1, 1, 1, 0, 1, 1);
        vecs[14] = mk(0, 0, 0, 1, 1, 1, 0, 0, 1);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].sel, vecs[i].run, vecs[i].exp, "vec", i);
        end

        // Same-select request: immediate done, no gate activity.
        step(0, 1, 2'd1, 1, mke(1, 1, 0, 1, 1), "same_sel", 0);
        step(0, 0, 2'd0, 1, mke(1, 1, 0, 0, 1), "same_sel", 1);

        // run_en dropped mid-SWITCH stays honoured from GATE_ON onward.
        do_switch(2'd1, 2'd0, 99, 11, "sw_1_0");
        do_switch(2'd0, 2'd3, 5, 11, "sw_0_3_drop");
        step(0, 0, 2'd0, 0, mke(3, 0, 0, 0, 1), "idle_off", 0);

        // Reset while in SWITCH with the new select already applied.
        step(0, 0, 2'd0, 1, mke(3, 1, 0, 0, 1), "pre_abort", 0);
        do_switch(2'd3, 2'd1, 99, 6, "abort");
        step(1, 0, 2'd0, 1, mke(2, 0, 0, 0, 0), "abort_rst", 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 2'd0, 1, mke(2, 1, 0, 0, 1), "post_abort", k);
        end

`ifdef CLK_SWITCH_CTRL_QUEUE_EN
        do_switch(2'd2, 2'd0, 99, 11, "q_prep");
        for (int k = 0; k < 22; k++) begin
            e.sel   = (k < 4) ? 2'd0 : ((k < 14) ? 2'd1 : 2'd2);
            e.en    = ((k >= 8) && (k < 10)) || (k >= 18);
            e.busy  = (k < 20);
            e.done  = (k == 10) || (k == 20);
            e.ready = !((k >= 2) && (k < 10));
            step(0, (k == 0) || (k == 2), (k == 0) ? 2'd1 : 2'd2, 1, e, "q_chain", k);
        end
        for (int k = 0; k < 13; k++) begin
            e.sel   = (k < 4) ? 2'd2 : 2'd0;
            e.en    = (k >= 8);
            e.busy  = (k < 10);
            e.done  = (k == 10) || (k == 11);
            e.ready = !((k >= 3) && (k <= 10));
            step(0, (k == 0) || (k == 3), 2'd0, 1, e, "q_same", k);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
